// File: rtl/fp16_pkg.sv
// fp16_pkg: shared types, constants and unpack helpers for the binary16 adder
package fp16_pkg;
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  localparam int EXP_W = 5;
  localparam int FRAC_W = 10;
  localparam int EXT_W = 14;
  localparam int EXP_BIAS = 15;
  localparam int EXP_MAX = 31;
  localparam logic [15:0] QNAN = 16'h7E00;
  localparam int FL_INV = 3;
  localparam int FL_OVF = 2;
  localparam int FL_UNF = 1;
  localparam int FL_INX = 0;
  // {hidden, frac, G, R, S} with G/R/S cleared
  function automatic logic [EXT_W-1:0] ext(input logic [14:0] x);
    return {|x[EXP_W+FRAC_W-1:FRAC_W], x[FRAC_W-1:0], 3'b000};
  endfunction
  // subnormals use exponent 1 so they line up with the smallest normal
  function automatic logic [EXP_W-1:0] eexp(input logic [14:0] x);
    return x[EXP_W+FRAC_W-1:FRAC_W] == '0 ? EXP_W'(1) : x[EXP_W+FRAC_W-1:FRAC_W];
  endfunction
endpackage

// File: rtl/fp16_add_seq_if.sv
// fp16_add_seq_if: operation/result handshake bundle
//   IN_VALID/OUT_READY + IN_A, IN_B, IN_SUB : operation offered by upstream
//   OUT_VALID/IN_READY + OUT_RESULT, OUT_FLAGS : result taken by downstream
interface fp16_add_seq_if;
  logic        IN_VALID;
  logic        OUT_READY;
  logic [15:0] IN_A;
  logic [15:0] IN_B;
  logic        IN_SUB;
  logic        OUT_VALID;
  logic        IN_READY;
  logic [15:0] OUT_RESULT;
  logic [3:0]  OUT_FLAGS;
  modport slave (input IN_VALID, IN_A, IN_B, IN_SUB, IN_READY,
                 output OUT_READY, OUT_VALID, OUT_RESULT, OUT_FLAGS);
  modport master (output IN_VALID, IN_A, IN_B, IN_SUB, IN_READY,
                  input OUT_READY, OUT_VALID, OUT_RESULT, OUT_FLAGS);
endinterface

// File: rtl/fp16_lzc.sv
// fp16_lzc: leading-zero count of a 14-bit mantissa (14 when all zero)
//   i_a : mantissa, o_cnt : number of leading zeros
module fp16_lzc
  import fp16_pkg::*;
(
  input  logic [EXT_W-1:0] i_a,
  output logic [3:0]       o_cnt
);
  always_comb begin
    o_cnt = 4'd14;
    for (int i = 0; i < EXT_W; i++) if (i_a[i]) o_cnt = 4'(EXT_W - 1 - i);
  end
endmodule

// File: rtl/fp16_add_seq.sv
// fp16_add_seq: multi-cycle binary16 adder/subtractor, IDLE-ALIGN-ADD-NORM-ROUND-DONE
//   IN_CLK, IN_RST_N (sync, active-low) : clock and reset
//   bus (slave) : operation in (A, B, SUB), result out (RESULT, FLAGS)
module fp16_add_seq
  import fp16_pkg::*;
(
  input logic           IN_CLK,
  input logic           IN_RST_N,
  fp16_add_seq_if.slave bus
);
  state_t r_state, w_next;
  logic [15:0] r_a, r_b, r_res;
  logic r_sub, r_sgn, r_eff_sub, r_spec, r_inv;
  logic [15:0] r_spec_res;
  logic [5:0] r_exp;
  logic [EXT_W-1:0] r_ml, r_ms;
  logic [EXT_W:0] r_sum;
  logic [3:0] r_flags;
  always_ff @(posedge IN_CLK) r_state <= !IN_RST_N ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.IN_VALID ? ALIGN : IDLE;
      ALIGN:   w_next = ADD;
      ADD:     w_next = NORM;
      NORM:    w_next = ROUND;
      ROUND:   w_next = DONE;
      DONE:    w_next = bus.IN_READY ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  assign bus.OUT_READY = r_state == IDLE;
  assign bus.OUT_VALID = r_state == DONE;
  assign bus.OUT_RESULT = r_res;
  assign bus.OUT_FLAGS = r_flags;
  logic w_sa, w_sb, w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_inf_clash, w_lost;
  logic [15:0] w_big, w_sml;
  logic [4:0] w_diff;
  logic [3:0] w_sh;
  logic [EXT_W-1:0] w_ms_ext, w_shifted;
  assign w_sa = r_a[15];
  assign w_sb = r_b[15] ^ r_sub;
  assign w_nan_a = &r_a[14:10] & |r_a[9:0];
  assign w_nan_b = &r_b[14:10] & |r_b[9:0];
  assign w_inf_a = &r_a[14:10] & ~|r_a[9:0];
  assign w_inf_b = &r_b[14:10] & ~|r_b[9:0];
  assign w_inf_clash = w_inf_a & w_inf_b & (w_sa ^ w_sb);
  // ties keep A as the larger operand, so equal magnitudes take A's sign
  assign w_big = r_a[14:0] >= r_b[14:0] ? {w_sa, r_a[14:0]} : {w_sb, r_b[14:0]};
  assign w_sml = r_a[14:0] >= r_b[14:0] ? {w_sb, r_b[14:0]} : {w_sa, r_a[14:0]};
  assign w_diff = eexp(w_big[14:0]) - eexp(w_sml[14:0]);
  assign w_sh = w_diff > 5'd13 ? 4'd13 : w_diff[3:0];
  assign w_ms_ext = ext(w_sml[14:0]);
  assign w_shifted = w_ms_ext >> w_sh;
  assign w_lost = |(w_ms_ext & ~(14'h3FFF << w_sh));
  logic [3:0] w_lz, w_nsh;
  logic [5:0] w_lim, w_nexp;
  logic [EXT_W:0] w_norm;
  fp16_lzc u_lzc (.i_a(r_sum[EXT_W-1:0]), .o_cnt(w_lz));
  // left shift stops at exponent 1, leaving a subnormal mantissa
  assign w_lim = r_exp - 6'd1;
  assign w_nsh = {2'b00, w_lz} > w_lim ? w_lim[3:0] : w_lz;
  assign w_norm = r_sum[EXT_W] ? {1'b0, r_sum[EXT_W:2], |r_sum[1:0]} : {1'b0, r_sum[EXT_W-1:0] << w_nsh};
  assign w_nexp = r_sum[EXT_W] ? r_exp + 6'd1 : r_exp - {2'b00, w_nsh};
  logic w_up, w_inx, w_ovf, w_rs;
  logic [11:0] w_mr;
  logic [5:0] w_e;
  logic [4:0] w_ef;
  logic [9:0] w_frac;
  logic [15:0] w_res;
  logic [3:0] w_fl;
  assign w_up = r_sum[2] & (r_sum[1] | r_sum[0] | r_sum[3]);
  assign w_mr = {1'b0, r_sum[EXT_W-1:3]} + {11'b0, w_up};
  assign w_e = r_exp + {5'b0, w_mr[11]};
  // a subnormal that rounds up into bit 10 becomes the smallest normal
  assign w_ef = w_mr[11] ? w_e[4:0] : w_mr[10] ? r_exp[4:0] : 5'd0;
  assign w_frac = w_mr[11] ? w_mr[10:1] : w_mr[9:0];
  assign w_inx = |r_sum[2:0];
  assign w_ovf = w_e >= 6'(EXP_MAX);
  assign w_rs = w_mr == '0 && r_eff_sub ? 1'b0 : r_sgn;
  assign w_res = r_spec ? r_spec_res : w_ovf ? {r_sgn, 15'h7C00} : {w_rs, w_ef, w_frac};
  always_comb begin
    w_fl = '0;
    w_fl[FL_INV] = r_spec & r_inv;
    w_fl[FL_OVF] = ~r_spec & w_ovf;
    w_fl[FL_UNF] = ~r_spec & ~w_ovf & w_inx & (w_ef == '0);
    w_fl[FL_INX] = ~r_spec & (w_inx | w_ovf);
  end
  always_ff @(posedge IN_CLK)
    if (!IN_RST_N) begin
      r_res <= '0;
      r_flags <= '0;
    end else case (r_state)
      IDLE: if (bus.IN_VALID) begin
        r_a <= bus.IN_A;
        r_b <= bus.IN_B;
        r_sub <= bus.IN_SUB;
      end
      ALIGN: begin
        r_sgn <= w_big[15];
        r_exp <= {1'b0, eexp(w_big[14:0])};
        r_ml <= ext(w_big[14:0]);
        r_ms <= {w_shifted[EXT_W-1:1], w_shifted[0] | w_lost};
        r_eff_sub <= w_sa ^ w_sb;
        r_spec <= w_nan_a | w_nan_b | w_inf_a | w_inf_b;
        r_inv <= (w_nan_a & ~r_a[9]) | (w_nan_b & ~r_b[9]) | (~w_nan_a & ~w_nan_b & w_inf_clash);
        r_spec_res <= w_nan_a | w_nan_b | w_inf_clash ? QNAN : {w_inf_a ? w_sa : w_sb, 15'h7C00};
      end
      ADD: r_sum <= r_eff_sub ? {1'b0, r_ml} - {1'b0, r_ms} : {1'b0, r_ml} + {1'b0, r_ms};
      NORM: begin
        r_sum <= w_norm;
        r_exp <= w_nexp;
      end
      ROUND: begin
        r_res <= w_res;
        r_flags <= w_fl;
      end
      default: ;
    endcase
endmodule
